// File: rtl/vp_mode_sched.sv
// vp_mode_sched: frame-synchronous mode scheduler for the vp pipeline.
// Measures frame geometry from de/v_sync, declares timing lock, and applies the
// requested mode only at a locked frame boundary (RGB passthrough otherwise).
// Optional macro VP_MODE_AUTOCYCLE_EN: ignore sw_req and step the mode every
// CYCLE_FRAMES locked frame boundaries.
module vp_mode_sched #(
  parameter int unsigned CNT_W          = 12,
  parameter int unsigned MAX_MODE       = 4,
  parameter bit          VS_ACTIVE_HIGH = 1'b1
`ifdef VP_MODE_AUTOCYCLE_EN
  , parameter int unsigned CYCLE_FRAMES = 60
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_in,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  input  logic [2:0]       sw_req,
  output logic [2:0]       sw,
  output logic             locked,
  output logic             frame_start,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] height,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       MODE_MAX = 3'(MAX_MODE);

  typedef enum logic [1:0] {S_WAIT, S_MEAS, S_CHECK, S_LOCK} state_t;

  state_t           state_q;
  logic             vs_q, de_q;
  logic [CNT_W-1:0] px_cnt_q, px_cnt_d, ln_cnt_q, ln_cnt_d, line_w_q, line_w_d;
  logic             frame_bad_q, frame_bad_d;
  logic [CNT_W-1:0] ref_w_q, ref_h_q;
  logic [2:0]       sw_q;
  logic             locked_q, frame_start_q;
  logic [CNT_W-1:0] width_q, height_q;
  logic [15:0]      frame_cnt_q;

  logic             fb, de_fall, frame_ok, geom_match, enter_lock, stay_lock;
  logic [CNT_W-1:0] px_e, ln_e, lw_e;
  logic             bad_e;
  logic [2:0]       sw_enter, sw_stay;

  // h_sync is reserved for later passthrough checks
  logic unused_hsync;
  assign unused_hsync = h_sync_in;

  assign fb      = VS_ACTIVE_HIGH ? (v_sync_in & ~vs_q) : (~v_sync_in & vs_q);
  assign de_fall = de_q & ~de_in;

  // Per-frame geometry tracking; a fb cycle closes the frame and restarts the counters
  always_comb begin
    px_e  = px_cnt_q;
    ln_e  = ln_cnt_q;
    lw_e  = line_w_q;
    bad_e = frame_bad_q;
    if (de_fall) begin
      if (ln_cnt_q == '0) begin
        lw_e = px_cnt_q;
      end else if (px_cnt_q != line_w_q) begin
        bad_e = 1'b1;
      end
      if (ln_cnt_q == CNT_MAX) bad_e = 1'b1;
      else                     ln_e  = ln_cnt_q + CNT_W'(1);
      px_e = '0;
    end else if (de_in) begin
      if (px_cnt_q == CNT_MAX) bad_e = 1'b1;
      else                     px_e  = px_cnt_q + CNT_W'(1);
    end
    frame_ok   = !bad_e && (ln_e != '0);
    geom_match = (lw_e == ref_w_q) && (ln_e == ref_h_q);
    if (fb) begin
      // de high in the fb cycle belongs to the new frame
      px_cnt_d    = de_in ? CNT_W'(1) : '0;
      ln_cnt_d    = '0;
      line_w_d    = '0;
      frame_bad_d = 1'b0;
    end else begin
      px_cnt_d    = px_e;
      ln_cnt_d    = ln_e;
      line_w_d    = lw_e;
      frame_bad_d = bad_e;
    end
  end

  assign enter_lock = fb && (state_q == S_CHECK) && frame_ok && geom_match;
  assign stay_lock  = fb && (state_q == S_LOCK)  && frame_ok && geom_match;

`ifdef VP_MODE_AUTOCYCLE_EN
  localparam int unsigned CYC_W = $clog2(CYCLE_FRAMES + 1);

  logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc;
  logic [2:0]       unused_sw_req;
  assign unused_sw_req = sw_req;

  // Auto-cycle: step the mode every CYCLE_FRAMES locked boundaries
  always_comb begin
    cyc_inc  = cyc_q + CYC_W'(1);
    cyc_d    = cyc_q;
    sw_enter = '0;
    sw_stay  = sw_q;
    if (stay_lock) begin
      if (cyc_inc == CYC_W'(CYCLE_FRAMES)) begin
        cyc_d   = '0;
        sw_stay = (sw_q >= MODE_MAX) ? 3'd0 : sw_q + 3'(1);
      end else begin
        cyc_d = cyc_inc;
      end
    end else if (fb) begin
      cyc_d = '0;
    end
  end

  // Auto-cycle frame counter
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end
`else
  // Switch request: illegal codes keep the current mode
  always_comb begin
    sw_enter = (sw_req <= MODE_MAX) ? sw_req : sw_q;
    sw_stay  = sw_enter;
  end
`endif

  // Lock FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_WAIT;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      px_cnt_q      <= '0;
      ln_cnt_q      <= '0;
      line_w_q      <= '0;
      frame_bad_q   <= 1'b0;
      ref_w_q       <= '0;
      ref_h_q       <= '0;
      sw_q          <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      frame_cnt_q   <= '0;
    end else begin
      vs_q          <= v_sync_in;
      de_q          <= de_in;
      px_cnt_q      <= px_cnt_d;
      ln_cnt_q      <= ln_cnt_d;
      line_w_q      <= line_w_d;
      frame_bad_q   <= frame_bad_d;
      frame_start_q <= fb;
      if (fb) begin
        case (state_q)
          S_WAIT: state_q <= S_MEAS;
          S_MEAS: begin
            if (frame_ok) begin
              ref_w_q <= lw_e;
              ref_h_q <= ln_e;
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (enter_lock) begin
              state_q     <= S_LOCK;
              locked_q    <= 1'b1;
              width_q     <= ref_w_q;
              height_q    <= ref_h_q;
              frame_cnt_q <= '0;
              sw_q        <= sw_enter;
            end else if (frame_ok) begin
              ref_w_q <= lw_e;
              ref_h_q <= ln_e;
            end else begin
              state_q <= S_MEAS;
            end
          end
          S_LOCK: begin
            if (stay_lock) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
              sw_q        <= sw_stay;
            end else begin
              state_q  <= S_MEAS;
              locked_q <= 1'b0;
              sw_q     <= '0;
            end
          end
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end

  assign sw          = sw_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign width       = width_q;
  assign height      = height_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vp_mode_sched.sv
// Testbench for vp_mode_sched: directed frame sequences plus randomized
// frames, checked against a frame-level reference model.
module tb_vp_mode_sched;

  logic        clk = 1'b0;
  logic        rst, de_in, h_sync_in, v_sync_in;
  logic [2:0]  sw_req;
  logic [2:0]  sw;
  logic        locked, frame_start;
  logic [11:0] width, height;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vp_mode_sched #(
    .CNT_W(12), .MAX_MODE(4), .VS_ACTIVE_HIGH(1'b1)
`ifdef VP_MODE_AUTOCYCLE_EN
    , .CYCLE_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in), .sw_req(sw_req), .sw(sw), .locked(locked),
    .frame_start(frame_start), .width(width), .height(height),
    .frame_cnt(frame_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: frames are lists of line widths
  bit m_seen, m_lock;
  int m_run, m_pw, m_ph, m_w, m_h, m_fcnt, m_sw, m_cyc;
  int cur[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_lock = 0; m_run = 0; m_pw = 0; m_ph = 0;
    m_w = 0; m_h = 0; m_fcnt = 0; m_sw = 0; m_cyc = 0;
    cur.delete();
  endtask

  // A frame boundary: judge the completed frame and update expectations
  task automatic model_fb(input int req);
    bit ok;
    int gw, gh;
    if (!m_seen) begin
      m_seen = 1;
    end else begin
      gh = cur.size();
      ok = (gh > 0);
      gw = ok ? cur[0] : 0;
      foreach (cur[i]) if (cur[i] != gw) ok = 0;
      if (m_lock) begin
        if (ok && gw == m_w && gh == m_h) begin
          m_fcnt = (m_fcnt + 1) % 65536;
`ifdef VP_MODE_AUTOCYCLE_EN
          m_cyc++;
          if (m_cyc == 2) begin m_cyc = 0; m_sw = (m_sw + 1) % 5; end
`else
          if (req <= 4) m_sw = req;
`endif
        end else begin
          m_lock = 0; m_sw = 0; m_run = 0; m_cyc = 0;
        end
      end else begin
        if (!ok) m_run = 0;
        else begin
          if (m_run > 0 && gw == m_pw && gh == m_ph) m_run++;
          else m_run = 1;
          m_pw = gw; m_ph = gh;
        end
        if (m_run >= 2) begin
          m_lock = 1; m_w = gw; m_h = gh; m_fcnt = 0; m_run = 0;
`ifdef VP_MODE_AUTOCYCLE_EN
          m_sw = 0; m_cyc = 0;
`else
          if (req <= 4) m_sw = req;
`endif
        end
      end
    end
    cur.delete();
  endtask

  task automatic check_all(input string ph, input logic fs_exp);
    check({ph, "_frame_start"}, frame_start, fs_exp);
    check({ph, "_locked"}, locked, m_lock);
    check({ph, "_sw"}, sw, m_sw);
    if (m_lock) begin
      check({ph, "_width"}, width, m_w);
      check({ph, "_height"}, height, m_h);
      check({ph, "_frame_cnt"}, frame_cnt, m_fcnt);
    end
  endtask

  task automatic check_zero(input string ph);
    check({ph, "_frame_start"}, frame_start, 0);
    check({ph, "_locked"}, locked, 0);
    check({ph, "_sw"}, sw, 0);
    check({ph, "_width"}, width, 0);
    check({ph, "_height"}, height, 0);
    check({ph, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // One frame: v_sync pulse (boundary), blanking, h lines of w pixels.
  // bad_line gets w-1 pixels; req_mid is applied halfway through the frame;
  // rst_line pulses rst for one cycle inside that line.
  task automatic run_frame(input string ph, input int w, input int h, input int bad_line,
                           input logic [2:0] req_fb, input logic [2:0] req_mid,
                           input int rst_line);
    int lw, gap;
    @(negedge clk);
    sw_req = req_fb; v_sync_in = 1'b1; de_in = 1'b0; h_sync_in = 1'b0;
    model_fb(int'(req_fb));
    @(negedge clk);
    check_all({ph, "_fb"}, 1'b1);
    @(negedge clk);
    check({ph, "_fs_pulse_end"}, frame_start, 0);
    v_sync_in = 1'b0;
    @(negedge clk);
    for (int l = 0; l < h; l++) begin
      lw = (l == bad_line) ? w - 1 : w;
      cur.push_back(lw);
      if (l == h / 2) sw_req = req_mid;
      for (int p = 0; p < lw; p++) begin
        @(negedge clk);
        de_in = 1'b1; h_sync_in = 1'b0;
        if (rst) begin
          rst = 1'b0;
          check_zero({ph, "_after_rst"});
          model_reset();
        end else if (l == rst_line && p == 2) begin
          rst = 1'b1;
        end
      end
      gap = 1 + int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge clk);
        de_in = 1'b0; h_sync_in = 1'b1;
      end
    end
    @(negedge clk);
    h_sync_in = 1'b0;
    check({ph, "_end_sw"}, sw, m_sw);
    check({ph, "_end_locked"}, locked, m_lock);
  endtask

  initial begin
    int gw, gh, bad;
    rst = 1'b1; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; sw_req = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Acquire lock on 8x4 frames with sw_req=3
    repeat (3) run_frame("lock", 8, 4, -1, 3'd3, 3'd3, -1);
    // Mid-frame request change, then illegal request
    run_frame("midreq", 8, 4, -1, 3'd3, 3'd1, -1);
    run_frame("apply1", 8, 4, -1, 3'd1, 3'd1, -1);
    run_frame("illegal", 8, 4, -1, 3'd6, 3'd6, -1);
    // One short line drops lock; two good frames relock
    run_frame("short", 8, 4, 2, 3'd1, 3'd1, -1);
    repeat (3) run_frame("relock", 8, 4, -1, 3'd2, 3'd2, -1);
    // Geometry change to 10x6
    repeat (5) run_frame("geom", 10, 6, -1, 3'd4, 3'd4, -1);
    // Synchronous reset mid-frame while locked
    run_frame("rstmid", 10, 6, -1, 3'd4, 3'd4, 1);
    repeat (4) run_frame("postrst", 8, 4, -1, 3'd3, 3'd0, -1);

    // Randomized frames
    gw = 8; gh = 4;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        gw = int'($urandom_range(4, 12));
        gh = int'($urandom_range(2, 6));
      end
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, gh - 1)) : -1;
      run_frame("rand", gw, gh, bad, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), -1);
    end
    run_frame("final", 8, 4, -1, 3'd0, 3'd0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vp_mode_sched.md
Name: vp_mode_sched

Overview:
- Frame-synchronous controller for the vp video-processing pipeline. Sits between the board switches and the vp mode input, on the rx pixel clock.
- Measures incoming frame geometry from de/h_sync/v_sync and declares timing lock.
- Applies a requested processing mode only at a frame boundary, and only while locked. This prevents mid-frame mode changes and tearing.
- Forces RGB passthrough (mode 0) whenever input timing is absent or unstable.

Parameters:
- CNT_W, 12, width of pixel/line counters and the geometry outputs.
- MAX_MODE, 4, highest legal mode code (0 RGB, 1 YCbCr, 2 binarize, 3 CoM cross, 4 CoM circle).
- VS_ACTIVE_HIGH, 1, v_sync polarity: 1 = frame boundary on v_sync rising edge, 0 = on falling edge.
- CYCLE_FRAMES, 60, frames per mode step in auto-cycle mode (optional feature only).

Ports:
- clk  in  1  pixel clock (rx_pclk)
- rst  in  1  synchronous reset, active-high
- de_in  in  1  data enable from HDMI input
- h_sync_in  in  1  horizontal sync (not used for measurement; reserved for passthrough checks)
- v_sync_in  in  1  vertical sync
- sw_req  in  3  requested mode from switches
- sw  out  3  active mode driven to vp.sw
- locked  out  1  input timing stable
- frame_start  out  1  one-cycle pulse at each detected frame boundary
- width  out  CNT_W  measured active pixels per line (valid when locked)
- height  out  CNT_W  measured active lines per frame (valid when locked)
- frame_cnt  out  16  frames counted since lock, wraps at 0xFFFF->0

Behaviour:
- Reset values: sw=0, locked=0, frame_start=0, width=0, height=0, frame_cnt=0, state=S_WAIT, all counters 0.
- Frame boundary (fb) is the v_sync active edge, detected against a registered copy of v_sync_in. frame_start is asserted the cycle after that edge (1-cycle latency).
- Within a frame:
  - px_cnt counts de_in-high cycles of the current line and clears on the de falling edge.
  - On each de falling edge: if first line of the frame, line_w := px_cnt; otherwise, if px_cnt != line_w, set frame_bad.
  - ln_cnt increments on each de falling edge.
  - All counters saturate at 2^CNT_W-1; saturation sets frame_bad.
- At each fb, the completed frame yields (line_w, ln_cnt, frame_bad). frame_ok = !frame_bad && ln_cnt!=0. Per-frame state is then cleared.
- FSM:
  - S_WAIT: wait for first fb; discard the partial frame -> S_MEAS.
  - S_MEAS: at fb, if frame_ok, store ref_w/ref_h -> S_CHECK; else stay in S_MEAS.
  - S_CHECK: at fb, if frame_ok and geometry matches ref -> S_LOCK (locked=1, width/height := ref, frame_cnt := 0). If frame_ok but geometry differs, reload ref and stay in S_CHECK. If !frame_ok -> S_MEAS.
  - S_LOCK: at each fb, if frame_ok and geometry matches ref, frame_cnt++. Otherwise -> S_MEAS with locked=0 and sw=0 in the same cycle as the fb update.
- Mode application:
  - sw updates only in the fb cycle while in (or entering) S_LOCK.
  - New value is sw_req sampled at that fb, if sw_req <= MAX_MODE; otherwise sw holds its previous value.
  - sw_req changes between boundaries have no effect on sw.
  - Outside S_LOCK, sw=0.
- A fb with de_in high in the same cycle is counted as belonging to the new frame.
- rst asserted mid-frame: returns to reset state next clock; the partial frame is discarded.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro VP_MODE_AUTOCYCLE_EN.
- Defined: sw_req is ignored. While locked, a frame counter steps sw 0,1,..,MAX_MODE,0,... every CYCLE_FRAMES locked frame boundaries. The first step occurs CYCLE_FRAMES boundaries after lock. Losing lock resets sw=0 and the cycle counter.
- Undefined: sw follows sw_req as in Behaviour; no cycle counter is synthesized.

Test Plan:
- Synthetic stream of 8 px x 4 lines per frame, v_sync pulse between frames, sw_req=3 -> locked rises at 3rd fb; width=8, height=4; sw=3 from that fb; frame_start pulses once per frame.
- Locked, sw_req changes 3->1 mid-frame -> sw stays 3 until next fb, then 1; sw_req=6 at a fb -> sw holds 1.
- Locked, one line shortened to 7 px -> at that frame's fb locked=0, sw=0; relock after 2 further good 8x4 frames.
- Frame geometry change 8x4 -> 10x6 -> lock drops; reports width=10, height=6 after relock; frame_cnt restarts at 0 and increments by 1 per frame.
- rst asserted for 1 cycle mid-frame while locked -> all outputs 0 next cycle; lock regained only after S_WAIT plus 2 good frames.
- With VP_MODE_AUTOCYCLE_EN, CYCLE_FRAMES=2 -> sw sequence 0,1,2,3,4,0 changing every 2nd fb after lock, independent of sw_req.
